ifft4_stream: RTL and testbench
===============================

Name: ifft4_stream

Overview:
- Streaming 4-point inverse DFT, the return path to the team's forward 4-point FFT.
- Accepts four frequency-domain complex samples X[0..3] serially over a valid/ready input, computes two radix-2 stages, and emits four time-domain samples x[0..3] serially over a valid/ready output.
- Sample format matches the forward FFT path: 64-bit word {real[63:32], imag[31:0]}, each component two's-complement Q16.16 (1.0 = 32'h00010000).

Parameters:
- DW, 32, width of one real or imaginary component; sample word is 2*DW.
- FRAC, 16, fractional bits of a component; documentation and test constants only, not used in arithmetic.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low (0 = reset)
- in_valid  input  1  in_data holds a valid frequency sample
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  2*DW  frequency sample {re, im}, arriving in order X[0], X[1], X[2], X[3]
- out_valid  output  1  out_data holds a valid time sample
- out_ready  input  1  downstream accepts a sample this cycle
- out_data  output  2*DW  time sample {re, im}
- out_idx  output  2  index n of the sample on out_data
- busy  output  1  high in any state other than LOAD, or while LOAD holds 1 to 3 samples

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=LOAD, sample counter=0, in_ready=1, out_valid=0, out_data=0, out_idx=0, busy=0.
  - All sample and intermediate registers are cleared to 0.
  - Reset overrides every event in the same cycle, including reset mid-EMIT; partial frames are discarded.
- Handshakes:
  - Transfer occurs on a rising edge where valid=1 and ready=1.
  - in_ready=1 only in LOAD.
  - out_valid=1 only in EMIT.
  - out_data and out_idx are held stable while out_valid=1 and out_ready=0.
- FSM states and transitions:
  - LOAD: store in_data into X[cnt] on each input transfer and increment cnt. The transfer at cnt=3 moves to CALC1 and resets cnt to 0. Idle cycles with in_valid=0 do not advance cnt.
  - CALC1, one cycle, compute stage 1:
    - a0 = X0 + X2
    - a1 = X1 + X3
    - b0 = X0 - X2
    - b1 = j*(X1 - X3), where j*(r,i) = (-i, r)
    - Then go to CALC2.
  - CALC2, one cycle, compute stage 2:
    - x0 = a0 + a1
    - x2 = a0 - a1
    - x1 = b0 + b1
    - x3 = b0 - b1
    - Then go to EMIT with cnt=0.
  - EMIT: out_data = x[cnt] and out_idx = cnt, in natural order 0,1,2,3. Each output transfer increments cnt. The transfer at cnt=3 returns to LOAD with cnt=0.
- Latency:
  - out_valid rises in the third cycle after the edge that accepts X[3].
  - in_ready rises in the cycle after the edge that transfers x[3].
  - No frame overlap; minimum frame period is 4+2+4 = 10 cycles.
- Arithmetic:
  - Each component is sign-extended to DW+2 bits before stage 1.
  - Stage results are kept at full width DW+2; no overflow is possible internally.
  - Output narrowing is set by the optional feature below.
  - Negating the most negative value (32'h80000000) in the j-rotation is exact, because it is done at DW+2 width.

Optional Feature:
- Macro IFFT4_SCALE_EN.
- Defined: outputs are scaled by 1/4. Each component is arithmetic-shifted right by 2 from the DW+2 result, truncated toward minus infinity, then the low DW bits are taken. This gives the true inverse DFT, and the output never overflows.
- Undefined: no scaling. The low DW bits of the DW+2 result are taken (wrap modulo 2^DW). The caller owns the headroom.

Decomposition:
- Package ifft4_pkg:
  - state enum {LOAD, CALC1, CALC2, EMIT}
  - DW and FRAC defaults
  - Q16.16 constants ONE=32'h00010000 and NEG_ONE=32'hFFFF0000
  - complex-word pack/unpack helper functions
- Sub-module ifft4_bfly: combinational radix-2 butterfly on DW+2 components with a rot_j input that applies the +j rotation to the difference leg. Instantiated twice (stage-1 pair) and reused by mux for stage 2, or instantiated four times.

Test Plan:
- Impulse: X0=(ONE,0), X1..X3=0 -> scaled: x0..x3 all (32'h00004000,0); unscaled: all (ONE,0).
- DC bin: X0..X3 all (ONE,0) -> unscaled: x0=(32'h00040000,0), x1..x3=0; scaled: x0=(ONE,0), others 0.
- Single tone: X1=(ONE,0), others 0 -> unscaled: x0=(ONE,0), x1=(0,ONE), x2=(NEG_ONE,0), x3=(0,NEG_ONE), with out_idx 0,1,2,3.
- Backpressure/gaps: in_valid toggling 1-0-1 during LOAD, and out_ready low for 3 cycles on x1 -> out_data/out_idx held constant; cnt does not advance; correct values resume; in_ready=0 throughout CALC1..EMIT.
- Reset mid-EMIT: rst=0 after x1 transfers -> next cycle out_valid=0, in_ready=1, busy=0. A new impulse frame then yields the impulse response with no residue.
- Back-to-back frames with in_valid held high: second frame accepted only after x3 transfers; measured latency is exactly 3 cycles from X3 acceptance to out_valid.

Source files
------------

// File: rtl/ifft4_pkg.sv
// rtl/ifft4_pkg.sv - shared types, Q16.16 constants and complex-word helpers for the 4-point inverse DFT
package ifft4_pkg;

   localparam int DW   = 32;
   localparam int FRAC = 16;

   localparam logic [DW-1:0] ONE     = 32'h00010000;
   localparam logic [DW-1:0] NEG_ONE = 32'hFFFF0000;

   typedef enum logic [1:0] {LOAD, CALC1, CALC2, EMIT} state_t;

   function automatic logic [2*DW-1:0] cpack(input logic [DW-1:0] re, input logic [DW-1:0] im);
      return {re, im};
   endfunction

   function automatic logic [DW-1:0] cre(input logic [2*DW-1:0] w);
      return w[2*DW-1:DW];
   endfunction

   function automatic logic [DW-1:0] cim(input logic [2*DW-1:0] w);
      return w[DW-1:0];
   endfunction

endpackage

// File: rtl/ifft4_bfly.sv
// rtl/ifft4_bfly.sv - combinational radix-2 butterfly; rot_j multiplies the difference leg by +j
module ifft4_bfly #(
   parameter int W = 34
) (
   input  logic                rot_j,
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   output logic signed [W-1:0] s_re,
   output logic signed [W-1:0] s_im,
   output logic signed [W-1:0] d_re,
   output logic signed [W-1:0] d_im
);

   logic signed [W-1:0] dr;
   logic signed [W-1:0] di;

   assign s_re = a_re + b_re;
   assign s_im = a_im + b_im;
   assign dr   = a_re - b_re;
   assign di   = a_im - b_im;

   // j*(r,i) = (-i, r)
   assign d_re = rot_j ? -di : dr;
   assign d_im = rot_j ? dr  : di;

endmodule

// File: rtl/ifft4_stream.sv
// rtl/ifft4_stream.sv - streaming 4-point inverse DFT; define IFFT4_SCALE_EN for 1/4 output scaling
module ifft4_stream import ifft4_pkg::*; #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] out_data,
   output logic [1:0]      out_idx,
   output logic            busy
);

   localparam int W = DW + 2;

   state_t     state;
   logic [1:0] cnt;
   logic [1:0] nxt;

   logic signed [W-1:0] xr [4];
   logic signed [W-1:0] xi [4];
   logic signed [W-1:0] yr [4];
   logic signed [W-1:0] yi [4];
   logic signed [W-1:0] a0r, a0i, a1r, a1i, b0r, b0i, b1r, b1i;

   logic signed [W-1:0] p_a0r, p_a0i, p_a1r, p_a1i, p_b0r, p_b0i, p_b1r, p_b1i;
   logic signed [W-1:0] q_x0r, q_x0i, q_x1r, q_x1i, q_x2r, q_x2i, q_x3r, q_x3i;

   function automatic logic signed [W-1:0] sext(input logic [DW-1:0] c);
      return {{2{c[DW-1]}}, c};
   endfunction

   function automatic logic [DW-1:0] narrow(input logic signed [W-1:0] v);
`ifdef IFFT4_SCALE_EN
      return DW'(v >>> 2);
`else
      return DW'(v);
`endif
   endfunction

   assign nxt = cnt + 2'd1;

   ifft4_bfly #(.W(W)) u_s1_even (
      .rot_j(1'b0), .a_re(xr[0]), .a_im(xi[0]), .b_re(xr[2]), .b_im(xi[2]),
      .s_re(p_a0r), .s_im(p_a0i), .d_re(p_b0r), .d_im(p_b0i)
   );

   ifft4_bfly #(.W(W)) u_s1_odd (
      .rot_j(1'b1), .a_re(xr[1]), .a_im(xi[1]), .b_re(xr[3]), .b_im(xi[3]),
      .s_re(p_a1r), .s_im(p_a1i), .d_re(p_b1r), .d_im(p_b1i)
   );

   ifft4_bfly #(.W(W)) u_s2_sum (
      .rot_j(1'b0), .a_re(a0r), .a_im(a0i), .b_re(a1r), .b_im(a1i),
      .s_re(q_x0r), .s_im(q_x0i), .d_re(q_x2r), .d_im(q_x2i)
   );

   ifft4_bfly #(.W(W)) u_s2_dif (
      .rot_j(1'b0), .a_re(b0r), .a_im(b0i), .b_re(b1r), .b_im(b1i),
      .s_re(q_x1r), .s_im(q_x1i), .d_re(q_x3r), .d_im(q_x3i)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= LOAD;
         cnt       <= 2'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= 2'd0;
         busy      <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            xr[k] <= '0;
            xi[k] <= '0;
            yr[k] <= '0;
            yi[k] <= '0;
         end
         a0r <= '0; a0i <= '0; a1r <= '0; a1i <= '0;
         b0r <= '0; b0i <= '0; b1r <= '0; b1i <= '0;
      end else begin
         case (state)
            LOAD: begin
               // in_ready is 1 throughout LOAD, so in_valid alone qualifies a transfer
               if (in_valid) begin
                  xr[cnt] <= sext(in_data[2*DW-1:DW]);
                  xi[cnt] <= sext(in_data[DW-1:0]);
                  cnt     <= nxt;
                  busy    <= 1'b1;
                  if (cnt == 2'd3) begin
                     state    <= CALC1;
                     in_ready <= 1'b0;
                  end
               end
            end
            CALC1: begin
               a0r <= p_a0r; a0i <= p_a0i; a1r <= p_a1r; a1i <= p_a1i;
               b0r <= p_b0r; b0i <= p_b0i; b1r <= p_b1r; b1i <= p_b1i;
               state <= CALC2;
            end
            CALC2: begin
               yr[0] <= q_x0r; yi[0] <= q_x0i;
               yr[1] <= q_x1r; yi[1] <= q_x1i;
               yr[2] <= q_x2r; yi[2] <= q_x2i;
               yr[3] <= q_x3r; yi[3] <= q_x3i;
               out_data  <= cpack(narrow(q_x0r), narrow(q_x0i));
               out_idx   <= 2'd0;
               out_valid <= 1'b1;
               cnt       <= 2'd0;
               state     <= EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  if (cnt == 2'd3) begin
                     state     <= LOAD;
                     cnt       <= 2'd0;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     cnt      <= nxt;
                     out_idx  <= nxt;
                     out_data <= cpack(narrow(yr[nxt]), narrow(yi[nxt]));
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_ifft4_stream.sv
// tb/tb_ifft4_stream.sv - randomized self-checking bench against a direct inverse-DFT reference model
module tb_ifft4_stream;
   import ifft4_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [63:0] in_data = 64'd0;
   logic        in_ready, out_valid, busy;
   logic [63:0] out_data;
   logic [1:0]  out_idx;

   always #5 clk = ~clk;

   ifft4_stream dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
      .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [63:0] in_q  [$];
   logic [63:0] exp_d [$];
   logic [1:0]  exp_i [$];
   int          in_cnt = 0;
   int          out_cnt = 0;
   int          cyc = 0;
   int          x3_cyc = 0;
   bit          armed = 0;
   bit          held = 0;
   logic [63:0] held_d;
   logic [1:0]  held_i;

   function automatic logic [31:0] narrow_ref(input longint v);
`ifdef IFFT4_SCALE_EN
      return 32'(v >>> 2);
`else
      return 32'(v);
`endif
   endfunction

   // x[n] = sum_k X[k] * j^(n*k)
   task automatic model_frame();
      longint r [4];
      longint im [4];
      longint sr, si;
      for (int k = 0; k < 4; k++) begin
         r[k]  = longint'($signed(cre(in_q[k])));
         im[k] = longint'($signed(cim(in_q[k])));
      end
      for (int n = 0; n < 4; n++) begin
         sr = 0;
         si = 0;
         for (int k = 0; k < 4; k++) begin
            case ((n * k) % 4)
               0: begin sr += r[k];  si += im[k]; end
               1: begin sr -= im[k]; si += r[k];  end
               2: begin sr -= r[k];  si -= im[k]; end
               default: begin sr += im[k]; si -= r[k]; end
            endcase
         end
         exp_d.push_back(cpack(narrow_ref(sr), narrow_ref(si)));
         exp_i.push_back(2'(n));
      end
      in_q.delete();
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         in_q.delete();
         exp_d.delete();
         exp_i.delete();
         held = 0;
         armed = 1;
      end else if (armed) begin
         check("in_ready", 64'(in_ready), 64'(exp_d.size() == 0));
         check("out_valid", 64'(out_valid), 64'(exp_d.size() != 0 && (cyc - x3_cyc) >= 3));
         check("busy", 64'(busy), 64'(in_q.size() != 0 || exp_d.size() != 0));
         if (held) begin
            check("hold_data", out_data, held_d);
            check("hold_idx", 64'(out_idx), 64'(held_i));
         end
         held = 0;
         if (out_valid && !out_ready) begin
            held   = 1;
            held_d = out_data;
            held_i = out_idx;
         end
         if (in_valid && in_ready) begin
            check("no_overlap", 64'(exp_d.size()), 64'd0);
            in_q.push_back(in_data);
            in_cnt++;
            if (in_q.size() == 4) begin
               model_frame();
               x3_cyc = cyc;
            end
         end
         if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_d.size() == 0) begin
               check("unexpected_out", 64'd1, 64'd0);
            end else begin
               check($sformatf("x%0d_data", exp_i[0]), out_data, exp_d[0]);
               check("out_idx", 64'(out_idx), 64'(exp_i[0]));
               void'(exp_d.pop_front());
               void'(exp_i.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [63:0] f [4], input int gap_pct);
      int target, b;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = f[k];
         target   = in_cnt + 1;
         b = 0;
         do begin
            @(posedge clk); #1;
            b++;
         end while (in_cnt < target && b < 100);
         if (in_cnt < target) check("send_timeout", 64'(in_cnt), 64'(target));
      end
      in_valid = 1'b0;
   endtask

   task automatic recv(input int stall_idx, input int stall_len, input int abort_after);
      int start, stalled, b;
      start = out_cnt;
      stalled = 0;
      b = 0;
      out_ready = 1'b1;
      while ((out_cnt - start) < 4 && b < 200) begin
         if (abort_after >= 0 && (out_cnt - start) == abort_after) begin
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            out_ready = 1'b1;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_busy", 64'(busy), 64'd0);
            return;
         end
         if (out_valid && int'(out_idx) == stall_idx && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
         b++;
      end
      out_ready = 1'b1;
      check("recv_count", 64'(out_cnt - start), 64'd4);
   endtask

   function automatic logic [31:0] rnd_comp();
      if ($urandom_range(7) == 0) return 32'h80000000;
      return $urandom();
   endfunction

   logic [63:0] fr [4];
   logic [63:0] fb [4];

   initial begin
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      check("reset_out_data", out_data, 64'd0);
      check("reset_out_idx", 64'(out_idx), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);

      fr = '{cpack(ONE, 32'd0), 64'd0, 64'd0, 64'd0};
      send(fr, 0); recv(-1, 0, -1);

      fr = '{cpack(ONE, 32'd0), cpack(ONE, 32'd0), cpack(ONE, 32'd0), cpack(ONE, 32'd0)};
      send(fr, 0); recv(-1, 0, -1);

      fr = '{64'd0, cpack(ONE, 32'd0), 64'd0, 64'd0};
      send(fr, 0); recv(-1, 0, -1);

      fr = '{cpack(NEG_ONE, ONE), cpack(ONE, 32'd0), cpack(32'h80000000, 32'h80000000), cpack(32'h7FFFFFFF, 32'h80000000)};
      send(fr, 100); recv(1, 3, -1);

      for (int k = 0; k < 4; k++) fr[k] = cpack(rnd_comp(), rnd_comp());
      send(fr, 0); recv(-1, 0, 2);

      fr = '{cpack(ONE, 32'd0), 64'd0, 64'd0, 64'd0};
      send(fr, 0); recv(-1, 0, -1);

      for (int k = 0; k < 4; k++) begin
         fr[k] = cpack(rnd_comp(), rnd_comp());
         fb[k] = cpack(rnd_comp(), rnd_comp());
      end
      send(fr, 0);
      in_valid = 1'b1;
      in_data  = fb[0];
      recv(-1, 0, -1);
      send(fb, 0);
      recv(-1, 0, -1);

      for (int f = 0; f < 20; f++) begin
         for (int k = 0; k < 4; k++) fr[k] = cpack(rnd_comp(), rnd_comp());
         send(fr, 30);
         recv($urandom_range(3), $urandom_range(3), -1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("drained_out", 64'(exp_d.size()), 64'd0);
      check("drained_in", 64'(in_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
